// File: rtl/mp1_mem_responder.sv
// rtl/mp1_mem_responder.sv - LC-3b memory responder with fixed latency and byte-masked writes
// Optional checker: define MEM_PROTOCOL_CHECK_EN to enable the sticky proto_err flag.
module mp1_mem_responder #(
   parameter int ADDR_BITS = 10,
   parameter int LATENCY   = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [1:0]  mem_byte_enable,
   input  logic [15:0] mem_address,
   input  logic [15:0] mem_wdata,
   output logic        mem_resp,
   output logic [15:0] mem_rdata,
   output logic        proto_err
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);
   localparam bit         DIRECT = (LATENCY == 1);

   logic [1:0]           state;
   logic [3:0]           cnt;
   logic                 lat_write;
   logic [ADDR_BITS-1:0] lat_index;
   logic [15:0]          lat_wdata;
   logic [1:0]           lat_be;

   logic [15:0] mem_array [0:(1<<ADDR_BITS)-1];

   logic                 req;
   logic                 fire;
   logic                 acc_write;
   logic [ADDR_BITS-1:0] acc_index;
   logic [15:0]          acc_wdata;
   logic [1:0]           acc_be;

   logic unused_addr_bits;
   assign unused_addr_bits = ^{mem_address[15:ADDR_BITS+1], mem_address[0]};

   assign req      = mem_read | mem_write;
   assign mem_resp = (state == RESP);

   // With LATENCY=1 the access happens on the sampling edge itself, straight from the inputs.
   always_comb begin
      fire      = 1'b0;
      acc_write = lat_write;
      acc_index = lat_index;
      acc_wdata = lat_wdata;
      acc_be    = lat_be;
      if (DIRECT && state == IDLE && req) begin
         fire      = 1'b1;
         acc_write = mem_write;
         acc_index = mem_address[ADDR_BITS:1];
         acc_wdata = mem_wdata;
         acc_be    = mem_byte_enable;
      end else if (state == BUSY && cnt == 4'd1) begin
         fire = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         mem_rdata <= 16'h0000;
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  lat_write <= mem_write;
                  lat_index <= mem_address[ADDR_BITS:1];
                  lat_wdata <= mem_wdata;
                  lat_be    <= mem_byte_enable;
                  cnt       <= LAT_M1;
                  state     <= DIRECT ? RESP : BUSY;
               end
            end
            BUSY: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  state <= RESP;
               end
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
         if (fire && !acc_write) begin
            mem_rdata <= mem_array[acc_index];
         end
      end
   end

   // The array has no reset; a completion edge that coincides with reset is suppressed.
   always_ff @(posedge clk) begin
      if (rst_n && fire && acc_write) begin
         if (acc_be[0]) mem_array[acc_index][7:0]  <= acc_wdata[7:0];
         if (acc_be[1]) mem_array[acc_index][15:8] <= acc_wdata[15:8];
      end
   end

`ifdef MEM_PROTOCOL_CHECK_EN
   logic [15:0] lat_address;
   logic        violation;
   logic        proto_err_q;

   always_ff @(posedge clk) begin
      if (state == IDLE && req) begin
         lat_address <= mem_address;
      end
   end

   always_comb begin
      violation = mem_read & mem_write;
      if (state == IDLE && mem_write && mem_byte_enable == 2'b00) begin
         violation = 1'b1;
      end
      if (state == BUSY) begin
         if (lat_write ? (!mem_write || mem_read) : (!mem_read || mem_write)) violation = 1'b1;
         if (mem_address != lat_address)  violation = 1'b1;
         if (mem_wdata != lat_wdata)      violation = 1'b1;
         if (mem_byte_enable != lat_be)   violation = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         proto_err_q <= 1'b0;
      end else if (violation) begin
         proto_err_q <= 1'b1;
      end
   end

   assign proto_err = proto_err_q;
`else
   assign proto_err = 1'b0;
`endif

endmodule
